// File: rtl/log2_fixed_point_pkg.sv
// ---------------------------------------------------------------------------
// log2_fixed_point_pkg
//   Shared constants and helpers for the log2 fixed-point datapath.
//   LOG2_WORD_W : width of the unsigned input word
//   LOG2_CLZ_W  : width of the leading-zero count bus out of the CLZ chain
//   LOG2_INT_W  : width of the integer part of log2 (must hold WORD_W-1)
//   LOG2_FRAC_W : width of the normalised mantissa (WORD_W-1)
//   clz_sat()   : clamps a leading-zero count to WORD_W, so any count of
//                 WORD_W or more uniformly means "the word was zero"
// ---------------------------------------------------------------------------
package log2_fixed_point_pkg;

  localparam int LOG2_WORD_W = 8;
  localparam int LOG2_CLZ_W  = 8;
  localparam int LOG2_INT_W  = 4;
  localparam int LOG2_FRAC_W = LOG2_WORD_W - 1;

  // Malformed counts above WORD_W collapse onto WORD_W, the zero-input code.
  function automatic logic [LOG2_CLZ_W-1:0] clz_sat(input logic [LOG2_CLZ_W-1:0] clz);
    logic [LOG2_CLZ_W-1:0] limit;
    limit = LOG2_CLZ_W'(LOG2_WORD_W);
    return (clz > limit) ? limit : clz;
  endfunction

endpackage

// File: rtl/log2_norm_shifter.sv
// ---------------------------------------------------------------------------
// log2_norm_shifter
//   Combinational logarithmic left barrel shifter used to normalise the input
//   word so that its leading one lands in the MSB. Zeros shift in from the
//   right. A shift amount of WORD_W or more yields an all-zero word.
//   Ports:
//     data_in   : word to normalise
//     shift_amt : left shift distance (saturated leading-zero count)
//     data_out  : data_in << shift_amt, truncated to WORD_W bits
// ---------------------------------------------------------------------------
module log2_norm_shifter
  import log2_fixed_point_pkg::*;
#(
  parameter int WORD_W = LOG2_WORD_W,
  parameter int SH_W   = $clog2(LOG2_WORD_W + 1)
) (
  input  logic [WORD_W-1:0] data_in,
  input  logic [SH_W-1:0]   shift_amt,
  output logic [WORD_W-1:0] data_out
);

  // stage[k] holds the word after the k least significant shift bits applied;
  // each level either passes through or shifts by 2**k.
  logic [WORD_W-1:0] stage [0:SH_W];

  assign stage[0] = data_in;

  for (genvar k = 0; k < SH_W; k++) begin : g_level
    assign stage[k+1] = shift_amt[k] ? (stage[k] << (2 ** k)) : stage[k];
  end

  assign data_out = stage[SH_W];

endmodule

// File: rtl/log2_normalize_stage.sv
// ---------------------------------------------------------------------------
// log2_normalize_stage
//   Consumes the original word plus its leading-zero count from the CLZ chain
//   and produces floor(log2(word)) and the MSB-aligned fraction below the
//   leading one. Two registered stages with valid/ready backpressure; latency
//   two cycles, throughput one word per cycle.
//   Ports:
//     clk      : single rising-edge clock
//     reset    : asynchronous active-high reset, clears all state
//     i_VALID  : upstream word/count valid
//     o_READY  : stage accepts this cycle
//     i_WORD   : original unsigned input word
//     i_RESULT : leading-zero count of i_WORD
//     o_VALID  : output bundle valid
//     i_READY  : downstream accepts this cycle
//     o_INT    : WORD_W-1-clz, or 0 for a zero word
//     o_FRAC   : (word << clz)[WORD_W-2:0], or 0 for a zero word
//     o_ZERO   : input word was zero (count saturated at WORD_W)
// ---------------------------------------------------------------------------
module log2_normalize_stage
  import log2_fixed_point_pkg::*;
#(
  parameter int WORD_W = LOG2_WORD_W,
  parameter int CLZ_W  = LOG2_CLZ_W,
  parameter int INT_W  = LOG2_INT_W,
  parameter int FRAC_W = LOG2_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_VALID,
  output logic              o_READY,
  input  logic [WORD_W-1:0] i_WORD,
  input  logic [CLZ_W-1:0]  i_RESULT,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic [INT_W-1:0]  o_INT,
  output logic [FRAC_W-1:0] o_FRAC,
  output logic              o_ZERO
);

  // Enough bits to carry a saturated count of 0..WORD_W.
  localparam int SH_W = $clog2(WORD_W + 1);

  logic              adv1;
  logic              adv2;

  logic [CLZ_W-1:0]  clz_full;
  logic [SH_W-1:0]   clz_sh;
  logic              in_zero;
  logic [WORD_W-1:0] shifted;

  logic              s1_v;
  logic [WORD_W-1:0] s1_shifted;
  logic [SH_W-1:0]   s1_clz;
  logic              s1_zero;

  logic [INT_W-1:0]  int_next;
  logic [FRAC_W-1:0] frac_next;

  // After saturation the count is at most WORD_W, so the high bits are always
  // zero; after normalisation the leading one sits in the MSB, which the
  // fraction deliberately drops.
  logic [CLZ_W-SH_W-1:0] unused_clz_hi;
  logic                  unused_shifted_msb;

  // Stall chain: a stage may load when it is empty or its successor moves,
  // so bubbles are always absorbed regardless of i_READY.
  assign adv2    = ~o_VALID | i_READY;
  assign adv1    = ~s1_v | adv2;
  assign o_READY = adv1;

  assign clz_full      = clz_sat(i_RESULT);
  assign clz_sh        = clz_full[SH_W-1:0];
  assign unused_clz_hi = clz_full[CLZ_W-1:SH_W];
  assign in_zero       = (clz_full == CLZ_W'(WORD_W));

  log2_norm_shifter #(
    .WORD_W (WORD_W),
    .SH_W   (SH_W)
  ) u_shifter (
    .data_in   (i_WORD),
    .shift_amt (clz_sh),
    .data_out  (shifted)
  );

  // Stage 1: capture the normalised word and saturated count. Data registers
  // only move on an actual load so idle cycles do not toggle them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v       <= 1'b0;
      s1_shifted <= '0;
      s1_clz     <= '0;
      s1_zero    <= 1'b0;
    end else if (adv1) begin
      s1_v <= i_VALID;
      if (i_VALID) begin
        s1_shifted <= shifted;
        s1_clz     <= clz_sh;
        s1_zero    <= in_zero;
      end
    end
  end

  // A nonzero word has a count of at most WORD_W-1, so the subtraction never
  // wraps; a zero word is forced to 0 instead.
  assign int_next  = s1_zero ? '0 : (INT_W'(WORD_W - 1) - INT_W'(s1_clz));
  assign frac_next = s1_zero ? '0 : FRAC_W'(s1_shifted[WORD_W-2:0]);
  assign unused_shifted_msb = s1_shifted[WORD_W-1];

  // Stage 2: registered outputs, held while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_VALID <= 1'b0;
      o_INT   <= '0;
      o_FRAC  <= '0;
      o_ZERO  <= 1'b0;
    end else if (adv2) begin
      o_VALID <= s1_v;
      if (s1_v) begin
        o_INT  <= int_next;
        o_FRAC <= frac_next;
        o_ZERO <= s1_zero;
      end
    end
  end

endmodule
